// File: rtl/alu_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alu_seq_pkg
//  Brief    : Instruction layout, flag positions and field decode for the
//             shared-ALU sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
package alu_seq_pkg;

    localparam int OPC_W   = 4;
    localparam int DATA_W  = 8;
    localparam int INSTR_W = 20;

    localparam int OPC_MSB = 19;
    localparam int OPC_LSB = 16;
    localparam int A_MSB   = 15;
    localparam int A_LSB   = 8;
    localparam int B_MSB   = 7;
    localparam int B_LSB   = 0;

    localparam int FLG_C = 3;
    localparam int FLG_V = 2;
    localparam int FLG_N = 1;
    localparam int FLG_Z = 0;

    typedef struct packed {
        logic [OPC_W-1:0]  opc;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } instrFields_t;

    function automatic instrFields_t decodeInstr(input logic [INSTR_W-1:0] instr);
        instrFields_t f;
        f.opc = instr[OPC_MSB:OPC_LSB];
        f.a   = instr[A_MSB:A_LSB];
        f.b   = instr[B_MSB:B_LSB];
        return f;
    endfunction

endpackage : alu_seq_pkg
`default_nettype wire

// File: rtl/alu_rr_sequencer_rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arb2
//  Brief    : Two-way round-robin arbiter; on contention the requester that
//             did not win last time is granted.
//  Revision : 1.0 - initial release
// ============================================================================
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       en,
    input  logic       last_grant,
    output logic [1:0] gnt,
    output logic       gnt_id
);

    always_comb begin
        gnt    = 2'b00;
        gnt_id = 1'b0;
        if (en) begin
            unique case (req)
                2'b01:   begin gnt = 2'b01; gnt_id = 1'b0; end
                2'b10:   begin gnt = 2'b10; gnt_id = 1'b1; end
                2'b11:   begin
                    gnt_id = ~last_grant;
                    gnt    = last_grant ? 2'b01 : 2'b10;
                end
                default: begin gnt = 2'b00; gnt_id = 1'b0; end
            endcase
        end
    end

endmodule : rr_arb2
`default_nettype wire

// File: rtl/alu_rr_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : alu_rr_sequencer
//  Brief    : Round-robin shares one combinational ALU between two requesters
//             and returns registered results over a valid/ready channel.
//  Revision : 1.0 - initial release
// ============================================================================
module alu_rr_sequencer
    import alu_seq_pkg::*;
#(
    parameter int CNT_W = 16,
    parameter int OPC_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req0_valid,
    output logic               req0_ready,
    input  logic [19:0]        req0_instr,
    input  logic               req1_valid,
    output logic               req1_ready,
    input  logic [19:0]        req1_instr,
    output logic [OPC_W-1:0]   alu_sel,
    output logic [7:0]         alu_a,
    output logic [7:0]         alu_b,
    input  logic [7:0]         alu_y,
    input  logic               alu_c,
    input  logic               alu_v,
    input  logic               alu_n,
    input  logic               alu_z,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic               rsp_id,
    output logic [7:0]         rsp_y,
    output logic [3:0]         rsp_flags,
    output logic [CNT_W-1:0]   op_count
);

    logic               r_rspValid;
    logic               r_rspId;
    logic [DATA_W-1:0]  r_rspY;
    logic [3:0]         r_rspFlags;
    logic [CNT_W-1:0]   r_opCount;
    logic               r_lastGrant;

    logic               w_canIssue;
    logic [1:0]         w_gnt;
    logic               w_gntId;
    logic               w_accept;
    logic               w_drain;
    instrFields_t       w_fld;

    // Gating with rst_n keeps the ALU quiet and blocks any accept on a reset edge.
    assign w_canIssue = rst_n & (~r_rspValid | rsp_ready);

    rr_arb2 u_arb (
        .req        ({req1_valid, req0_valid}),
        .en         (w_canIssue),
        .last_grant (r_lastGrant),
        .gnt        (w_gnt),
        .gnt_id     (w_gntId)
    );

    assign req0_ready = w_gnt[0];
    assign req1_ready = w_gnt[1];
    assign w_accept   = (req0_valid & req0_ready) | (req1_valid & req1_ready);
    assign w_drain    = r_rspValid & rsp_ready;

    always_comb begin
        w_fld = '0;
        if (w_accept) begin
            w_fld = decodeInstr(w_gntId ? req1_instr : req0_instr);
        end
    end

    assign alu_sel = OPC_W'(w_fld.opc);
    assign alu_a   = w_fld.a;
    assign alu_b   = w_fld.b;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rspValid  <= 1'b0;
            r_rspId     <= 1'b0;
            r_rspY      <= '0;
            r_rspFlags  <= '0;
            r_opCount   <= '0;
            r_lastGrant <= 1'b1;
        end else begin
            if (w_accept) begin
                r_rspValid         <= 1'b1;
                r_rspId            <= w_gntId;
                r_rspY             <= alu_y;
                r_rspFlags[FLG_C]  <= alu_c;
                r_rspFlags[FLG_V]  <= alu_v;
                r_rspFlags[FLG_N]  <= alu_n;
                r_rspFlags[FLG_Z]  <= alu_z;
                r_lastGrant        <= w_gntId;
            end else if (w_drain) begin
                r_rspValid <= 1'b0;
            end

            if (w_drain && !(&r_opCount)) begin
                r_opCount <= r_opCount + CNT_W'(1);
            end
        end
    end

    assign rsp_valid = r_rspValid;
    assign rsp_id    = r_rspId;
    assign rsp_y     = r_rspY;
    assign rsp_flags = r_rspFlags;
    assign op_count  = r_opCount;

endmodule : alu_rr_sequencer
`default_nettype wire
